// File: rtl/hood_mode_ctrl.sv
// Range-hood mode scheduler: power, fan level, hurricane/drain timing and self-clean ownership.
// Optional self-clean timeout is enabled by defining HOOD_CLEAN_TIMEOUT_EN.
module hood_mode_ctrl #(
  parameter int PWR_HOLD_S      = 3,
  parameter int HURRICANE_S     = 60,
  parameter int DRAIN_S         = 60,
  parameter int CLEAN_TIMEOUT_S = 200,
  parameter int CW              = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick_1s,
  input  logic          pwr_btn,
  input  logic          lvl1_req,
  input  logic          lvl2_req,
  input  logic          lvl3_req,
  input  logic          stop_req,
  input  logic          clean_req,
  input  logic          clean_done,
  output logic          is_on,
  output logic [1:0]    fan_level,
  output logic          clean_start,
  output logic          clean_active,
  output logic          hurricane_used,
  output logic [CW-1:0] countdown_s,
  output logic          clean_fault,
  output logic [2:0]    state_o
);

  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_STBY  = 3'd1,
    S_L1    = 3'd2,
    S_L2    = 3'd3,
    S_L3    = 3'd4,
    S_DRAIN = 3'd5,
    S_CLEAN = 3'd6
  } state_t;

  localparam int HW = $clog2(PWR_HOLD_S + 1);

  state_t          state_r;
  state_t          state_nx_s;
  logic            pwr_d_r;
  logic [HW-1:0]   hold_r;
  logic [CW-1:0]   cnt_r;
  logic            hu_r;
  logic            clean_start_r;
  logic            is_on_r;
  logic [1:0]      fan_r;
  logic            ca_r;
  logic [1:0]      fan_nx_s;
  logic            pwr_rise_s;
  logic            poweroff_s;
  logic            lvl3_ok_s;
  logic            tick_one_s;
  logic            entering_s;
  logic            clean_ok_s;
  logic            timeout_s;

  assign pwr_rise_s = pwr_btn & ~pwr_d_r;
  // Fires on the tick that brings the hold count up to PWR_HOLD_S.
  assign poweroff_s = pwr_btn & tick_1s & (hold_r == HW'(PWR_HOLD_S - 1)) & (state_r != S_OFF);
  assign lvl3_ok_s  = lvl3_req & ~hu_r;
  assign tick_one_s = tick_1s & (cnt_r == CW'(1));
  assign entering_s = (state_nx_s != state_r);

`ifdef HOOD_CLEAN_TIMEOUT_EN
  logic fault_r;

  assign clean_ok_s  = ~fault_r;
  assign timeout_s   = tick_1s & (cnt_r == CW'(CLEAN_TIMEOUT_S - 1));
  assign clean_fault = fault_r;

  // Sticky timeout flag, cleared only by reset or power-off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_r <= 1'b0;
    end else if (entering_s && state_nx_s == S_OFF) begin
      fault_r <= 1'b0;
    end else if (state_r == S_CLEAN && timeout_s && !clean_done) begin
      fault_r <= 1'b1;
    end else begin
      fault_r <= fault_r;
    end
  end
`else
  assign clean_ok_s  = 1'b1;
  assign timeout_s   = 1'b0;
  assign clean_fault = 1'b0;
`endif

  // Next-state decode with poweroff > stop > lvl3 > lvl2 > lvl1 > clean priority.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_OFF: begin
        if (pwr_rise_s) state_nx_s = S_STBY;
        else            state_nx_s = S_OFF;
      end
      S_STBY: begin
        if (poweroff_s)                    state_nx_s = S_OFF;
        else if (lvl3_ok_s)                state_nx_s = S_L3;
        else if (lvl2_req)                 state_nx_s = S_L2;
        else if (lvl1_req)                 state_nx_s = S_L1;
        else if (clean_req && clean_ok_s)  state_nx_s = S_CLEAN;
        else                               state_nx_s = S_STBY;
      end
      S_L1, S_L2: begin
        if (poweroff_s)     state_nx_s = S_OFF;
        else if (stop_req)  state_nx_s = S_STBY;
        else if (lvl3_ok_s) state_nx_s = S_L3;
        else if (lvl2_req)  state_nx_s = S_L2;
        else if (lvl1_req)  state_nx_s = S_L1;
        else                state_nx_s = state_r;
      end
      S_L3: begin
        if (poweroff_s)      state_nx_s = S_OFF;
        else if (stop_req)   state_nx_s = S_DRAIN;
        else if (tick_one_s) state_nx_s = S_L2;
        else                 state_nx_s = S_L3;
      end
      S_DRAIN: begin
        if (poweroff_s)      state_nx_s = S_OFF;
        else if (tick_one_s) state_nx_s = S_STBY;
        else                 state_nx_s = S_DRAIN;
      end
      S_CLEAN: begin
        if (clean_done)     state_nx_s = S_STBY;
        else if (timeout_s) state_nx_s = S_STBY;
        else                state_nx_s = S_CLEAN;
      end
      default: state_nx_s = S_OFF;
    endcase
  end

  // Fan speed for the state being entered.
  always_comb begin
    fan_nx_s = 2'd0;
    case (state_nx_s)
      S_L1:          fan_nx_s = 2'd1;
      S_L2:          fan_nx_s = 2'd2;
      S_L3, S_DRAIN: fan_nx_s = 2'd3;
      default:       fan_nx_s = 2'd0;
    endcase
  end

  // State register and power-button edge history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_OFF;
      pwr_d_r <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      pwr_d_r <= pwr_btn;
    end
  end

  // Power-button hold counter; restarts on STBY entry so the power-on press never counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_r <= '0;
    end else if (state_r == S_OFF || !pwr_btn || (entering_s && state_nx_s == S_STBY)) begin
      hold_r <= '0;
    end else if (tick_1s && hold_r != HW'(PWR_HOLD_S)) begin
      hold_r <= hold_r + HW'(1);
    end else begin
      hold_r <= hold_r;
    end
  end

  // Countdown: loaded on entry (transition beats tick), down in L3/DRAIN, up in CLEAN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (entering_s) begin
      case (state_nx_s)
        S_L3:    cnt_r <= CW'(HURRICANE_S);
        S_DRAIN: cnt_r <= CW'(DRAIN_S);
        default: cnt_r <= '0;
      endcase
    end else if (tick_1s) begin
      case (state_r)
        S_L3, S_DRAIN: cnt_r <= cnt_r - CW'(1);
        S_CLEAN:       cnt_r <= (cnt_r == {CW{1'b1}}) ? cnt_r : cnt_r + CW'(1);
        default:       cnt_r <= cnt_r;
      endcase
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Hurricane-used flag and registered Moore outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hu_r          <= 1'b0;
      clean_start_r <= 1'b0;
      is_on_r       <= 1'b0;
      fan_r         <= 2'd0;
      ca_r          <= 1'b0;
    end else begin
      if (entering_s && state_nx_s == S_OFF)     hu_r <= 1'b0;
      else if (entering_s && state_nx_s == S_L3) hu_r <= 1'b1;
      else                                       hu_r <= hu_r;
      clean_start_r <= entering_s && (state_nx_s == S_CLEAN);
      is_on_r       <= (state_nx_s != S_OFF);
      fan_r         <= fan_nx_s;
      ca_r          <= (state_nx_s == S_CLEAN);
    end
  end

  assign is_on          = is_on_r;
  assign fan_level      = fan_r;
  assign clean_start    = clean_start_r;
  assign clean_active   = ca_r;
  assign hurricane_used = hu_r;
  assign countdown_s    = cnt_r;
  assign state_o        = state_r;

endmodule

// File: tb/tb_hood_mode_ctrl.sv
// Directed scoreboard bench for hood_mode_ctrl; timeout scenario runs when HOOD_CLEAN_TIMEOUT_EN is defined.
module tb_hood_mode_ctrl;

  localparam logic [2:0] OFF = 3'd0, STBY = 3'd1, L1 = 3'd2, L2 = 3'd3,
                         L3 = 3'd4, DRAIN = 3'd5, CLEAN = 3'd6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_1s = 1'b0, pwr_btn = 1'b0;
  logic       lvl1_req = 1'b0, lvl2_req = 1'b0, lvl3_req = 1'b0;
  logic       stop_req = 1'b0, clean_req = 1'b0, clean_done = 1'b0;
  logic       is_on, clean_start, clean_active, hurricane_used, clean_fault;
  logic [1:0] fan_level;
  logic [7:0] countdown_s;
  logic [2:0] state_o;

  int total = 0;
  int bad   = 0;
  logic [17:0] exp_q[$];
  string       tag_q[$];
  logic        cf_exp;

  hood_mode_ctrl #(.CLEAN_TIMEOUT_S(5)) dut (
    .clk(clk), .rst(rst), .tick_1s(tick_1s), .pwr_btn(pwr_btn),
    .lvl1_req(lvl1_req), .lvl2_req(lvl2_req), .lvl3_req(lvl3_req),
    .stop_req(stop_req), .clean_req(clean_req), .clean_done(clean_done),
    .is_on(is_on), .fan_level(fan_level), .clean_start(clean_start),
    .clean_active(clean_active), .hurricane_used(hurricane_used),
    .countdown_s(countdown_s), .clean_fault(clean_fault), .state_o(state_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Expected output vector from the state table: {state, fan, on, clean_active, hu, start, fault, countdown}.
  function automatic logic [17:0] ev(logic [2:0] st, logic hu, logic cs, logic cf, logic [7:0] cd);
    logic [1:0] fan;
    fan = (st == L1) ? 2'd1 : (st == L2) ? 2'd2 : (st == L3 || st == DRAIN) ? 2'd3 : 2'd0;
    return {st, fan, (st != OFF), (st == CLEAN), hu, cs, cf, cd};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    tick_1s = 1'b0; lvl1_req = 1'b0; lvl2_req = 1'b0; lvl3_req = 1'b0;
    stop_req = 1'b0; clean_req = 1'b0; clean_done = 1'b0;
  endtask

  task automatic go();
    cyc();
    clr();
  endtask

  task automatic push(string t, logic [17:0] e);
    tag_q.push_back(t);
    exp_q.push_back(e);
  endtask

  task automatic compare();
    logic [17:0] obs, e;
    string t;
    obs = {state_o, fan_level, is_on, clean_active, hurricane_used, clean_start, clean_fault, countdown_s};
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL scoreboard_empty observed=%h expected=entry", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", t, obs, e);
      end
    end
  endtask

  // Push expectation, clock once with current inputs, then compare.
  task automatic step(string t, logic [17:0] e);
    push(t, e);
    go();
    compare();
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) begin
      tick_1s = 1'b1;
      go();
    end
  endtask

  initial begin
    cf_exp = 1'b0;
    // Reset state
    cyc(); cyc();
    push("reset", ev(OFF, 1'b0, 1'b0, 1'b0, 8'd0));
    compare();
    rst = 1'b0;
    lvl1_req = 1'b1; clean_req = 1'b1;
    step("off_ignores", ev(OFF, 1'b0, 1'b0, 1'b0, 8'd0));

    // 1: power on, hurricane, expiry to L2
    pwr_btn = 1'b1;
    step("pwr_on", ev(STBY, 1'b0, 1'b0, 1'b0, 8'd0));
    pwr_btn = 1'b0; go();
    lvl3_req = 1'b1;
    step("l3_entry", ev(L3, 1'b1, 1'b0, 1'b0, 8'd60));
    ticks(59);
    push("l3_cd1", ev(L3, 1'b1, 1'b0, 1'b0, 8'd1)); compare();
    tick_1s = 1'b1;
    step("l3_expire", ev(L2, 1'b1, 1'b0, 1'b0, 8'd0));
    lvl3_req = 1'b1;
    step("l3_reuse", ev(L2, 1'b1, 1'b0, 1'b0, 8'd0));

    // 4: hold must be consecutive
    pwr_btn = 1'b1; ticks(2);
    push("hold2", ev(L2, 1'b1, 1'b0, 1'b0, 8'd0)); compare();
    pwr_btn = 1'b0; go();
    pwr_btn = 1'b1; ticks(2);
    push("hold_restart", ev(L2, 1'b1, 1'b0, 1'b0, 8'd0)); compare();
    tick_1s = 1'b1;
    step("poweroff", ev(OFF, 1'b0, 1'b0, 1'b0, 8'd0));
    pwr_btn = 1'b0; go();

    // 2: stop in L3 with a simultaneous tick, then drain
    pwr_btn = 1'b1; go(); pwr_btn = 1'b0; go();
    lvl3_req = 1'b1; go();
    ticks(20);
    push("l3_cd40", ev(L3, 1'b1, 1'b0, 1'b0, 8'd40)); compare();
    stop_req = 1'b1; tick_1s = 1'b1;
    step("drain_entry", ev(DRAIN, 1'b1, 1'b0, 1'b0, 8'd60));
    ticks(59);
    push("drain_cd1", ev(DRAIN, 1'b1, 1'b0, 1'b0, 8'd1)); compare();
    tick_1s = 1'b1;
    step("drain_done", ev(STBY, 1'b1, 1'b0, 1'b0, 8'd0));

    // Power cycle to clear hurricane_used
    pwr_btn = 1'b1; ticks(2); tick_1s = 1'b1;
    step("stby_off", ev(OFF, 1'b0, 1'b0, 1'b0, 8'd0));
    pwr_btn = 1'b0; go();
    pwr_btn = 1'b1; go(); pwr_btn = 1'b0; go();

    // 5: same-cycle priority
    lvl1_req = 1'b1; lvl3_req = 1'b1; clean_req = 1'b1;
    step("prio_l3", ev(L3, 1'b1, 1'b0, 1'b0, 8'd60));
    stop_req = 1'b1; go();
    stop_req = 1'b1; lvl1_req = 1'b1; tick_1s = 1'b1;
    step("drain_ignores", ev(DRAIN, 1'b1, 1'b0, 1'b0, 8'd59));
    ticks(59);
    push("drain_exit", ev(STBY, 1'b1, 1'b0, 1'b0, 8'd0)); compare();

    // 3: self-clean, power hold ignored
    clean_req = 1'b1;
    step("clean_start", ev(CLEAN, 1'b1, 1'b1, 1'b0, 8'd0));
    step("clean_pulse1", ev(CLEAN, 1'b1, 1'b0, 1'b0, 8'd0));
    pwr_btn = 1'b1; ticks(4);
    push("clean_hold", ev(CLEAN, 1'b1, 1'b0, 1'b0, 8'd4)); compare();
    pwr_btn = 1'b0; clean_done = 1'b1;
    step("clean_done", ev(STBY, 1'b1, 1'b0, 1'b0, 8'd0));
    clean_done = 1'b1;
    step("done_ignored", ev(STBY, 1'b1, 1'b0, 1'b0, 8'd0));

    // 6: timeout (macro) or indefinite wait
    clean_req = 1'b1; go();
    ticks(4);
    push("clean_cd4", ev(CLEAN, 1'b1, 1'b0, 1'b0, 8'd4)); compare();
`ifdef HOOD_CLEAN_TIMEOUT_EN
    tick_1s = 1'b1;
    step("clean_timeout", ev(STBY, 1'b1, 1'b0, 1'b1, 8'd0));
    clean_req = 1'b1;
    step("clean_rejected", ev(STBY, 1'b1, 1'b0, 1'b1, 8'd0));
    cf_exp = 1'b1;
`else
    tick_1s = 1'b1;
    step("clean_wait", ev(CLEAN, 1'b1, 1'b0, 1'b0, 8'd5));
    clean_done = 1'b1;
    step("clean_done2", ev(STBY, 1'b1, 1'b0, 1'b0, 8'd0));
`endif
    lvl1_req = 1'b1;
    step("stby_l1", ev(L1, 1'b1, 1'b0, cf_exp, 8'd0));

    // Power off clears fault, then reset in the middle of L3
    pwr_btn = 1'b1; ticks(2); tick_1s = 1'b1;
    step("off_clear", ev(OFF, 1'b0, 1'b0, 1'b0, 8'd0));
    pwr_btn = 1'b0; go();
    pwr_btn = 1'b1; go(); pwr_btn = 1'b0; go();
    lvl3_req = 1'b1; go();
    ticks(3);
    push("l3_pre_rst", ev(L3, 1'b1, 1'b0, 1'b0, 8'd57)); compare();
    #2 rst = 1'b1;
    #1;
    push("rst_mid_l3", ev(OFF, 1'b0, 1'b0, 1'b0, 8'd0)); compare();
    cyc();
    rst = 1'b0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
